he_lpbk_csr_sequencer: RTL and testbench
========================================

Name: he_lpbk_csr_sequencer

Overview:
- Hardware sequencer that programs and runs the HE memory-loopback engine through its CSR window, replacing host MMIO for self-test and bring-up.
- Sits between a simple start/status interface (from the test harness or BMC shim) and a single-outstanding CSR master port into the HE-mem CSR space.
- It writes configuration, pulses start, polls completion, reads ERROR, and reports pass/fail/timeout.

Parameters:
- ADDR_W, 16, CSR byte-offset width.
- POLL_GAP, 64, idle cycles between successive STATUS0 polls (>=1).
- MAX_POLLS, 4096, polls before timeout (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- abort  in  1  level; requests early termination.
- cfg_dsm_base  in  64  DSM base address.
- cfg_src_addr  in  64  source address.
- cfg_dst_addr  in  64  destination address.
- cfg_num_lines  in  32  line count (0 is legal).
- cfg_mode  in  64  value for CFG.
- csr_req_valid  out  1  request valid.
- csr_req_ready  in  1  request accepted.
- csr_req_write  out  1  1=write, 0=read.
- csr_req_addr  out  ADDR_W  byte offset.
- csr_req_wdata  out  64  write data.
- csr_rsp_valid  in  1  read data valid.
- csr_rsp_rdata  in  64  read data.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  sticky; valid at done.
- timeout  out  1  sticky.
- aborted  out  1  sticky.
- err_status  out  64  last ERROR value read.
- poll_count  out  16  polls issued in the current run.

Behaviour:
- Reset values: csr_req_valid=0; busy=0; done=0; pass=0; timeout=0; aborted=0; err_status=0; poll_count=0; state=IDLE.
- The cfg_* inputs are sampled into internal registers on an accepted start; later changes are ignored.
- Sticky outputs and poll_count clear on an accepted start.
- CSR handshake:
  - Request fields are held stable while csr_req_valid=1 and ready=0.
  - A write completes on the valid&&ready cycle (posted).
  - A read completes on the first csr_rsp_valid after acceptance; rsp_valid in any other state is ignored.
  - Only one transaction is outstanding at a time. The next request may be asserted the cycle after completion.
- States and writes (address=data), in order:
  - IDLE -(start)-> W_CTL0: 0x138=0
  - W_DSML: 0x110=dsm[31:0]
  - W_DSMH: 0x114=dsm[63:32]
  - W_SRC: 0x120=src
  - W_DST: 0x128=dst
  - W_NUM: 0x130={32'h0,num_lines}
  - W_CFG: 0x140=cfg_mode
  - W_CTL1: 0x138=1 (release reset)
  - W_CTL3: 0x138=3 (start)
  - Then GAP.
- GAP: count POLL_GAP cycles, then R_STAT.
- R_STAT: read 0x160; poll_count increments on acceptance.
  - If rdata[31:0] >= num_lines, go to R_ERR.
  - Else if poll_count==MAX_POLLS, set timeout=1 and go to W_STOP.
  - Else go to GAP.
- R_ERR: read 0x170; err_status<=rdata; pass<=(rdata==0); go to W_STOP.
- W_STOP: 0x138=1 (clear start); go to FIN.
- FIN: done=1 for one cycle; busy=0 the same cycle; go to IDLE.
- busy=1 in every state except IDLE.
- abort:
  - Sampled only at transaction completion or in GAP. Set aborted=1, pass=0, go to W_STOP. The current transaction is never dropped.
  - Abort while in W_STOP or FIN has no effect.
- start while busy is ignored. start and abort together in IDLE: start wins, and abort is evaluated at the first completion.
- num_lines=0: the first poll satisfies completion, so exactly 1 poll is issued.
- poll_count saturates at 16'hFFFF.
- Reset mid-operation: all state clears immediately and csr_req_valid drops asynchronously. No W_STOP is issued.

Test Plan:
- start with num_lines=8, ready=1, STATUS0 returns 8 on 3rd poll, ERROR=0 -> exactly 9 config writes in listed order, then 3 reads of 0x160, 1 read of 0x170, write 0x138=1; done pulse; pass=1, poll_count=3.
- ERROR returns 0x4 -> pass=0, err_status=0x4, done pulses once.
- STATUS0 never reaches num_lines, MAX_POLLS=4 -> 4 polls, timeout=1, no ERROR read, W_STOP issued, done.
- ready held low 5 cycles on W_SRC -> addr/wdata stable all 5 cycles, no skipped or duplicate writes.
- abort asserted during GAP after poll 1 -> next request is 0x138=1, aborted=1, pass=0, done. start pulse during busy -> ignored.
- rst_n low during R_STAT with rsp pending -> all outputs at reset values. A new start then begins at 0x138=0 with poll_count=0.

Source files
------------

// File: rtl/he_lpbk_csr_sequencer.sv
// Runs the HE memory-loopback self-test over a single-outstanding CSR master: programs config, starts, polls, reports.
// Request fields hold while csr_req_valid && !csr_req_ready; each new request is raised one cycle after the previous completes.
module he_lpbk_csr_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int POLL_GAP  = 64,
  parameter int MAX_POLLS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [63:0]       cfg_dsm_base,
  input  logic [63:0]       cfg_src_addr,
  input  logic [63:0]       cfg_dst_addr,
  input  logic [31:0]       cfg_num_lines,
  input  logic [63:0]       cfg_mode,
  output logic              csr_req_valid,
  input  logic              csr_req_ready,
  output logic              csr_req_write,
  output logic [ADDR_W-1:0] csr_req_addr,
  output logic [63:0]       csr_req_wdata,
  input  logic              csr_rsp_valid,
  input  logic [63:0]       csr_rsp_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              aborted,
  output logic [63:0]       err_status,
  output logic [15:0]       poll_count
);

  localparam int                GAP_W       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(POLL_GAP - 1);
  localparam logic [31:0]       MAX_POLLS_U = 32'(MAX_POLLS);

  localparam logic [ADDR_W-1:0] A_DSML = ADDR_W'(16'h110);
  localparam logic [ADDR_W-1:0] A_DSMH = ADDR_W'(16'h114);
  localparam logic [ADDR_W-1:0] A_SRC  = ADDR_W'(16'h120);
  localparam logic [ADDR_W-1:0] A_DST  = ADDR_W'(16'h128);
  localparam logic [ADDR_W-1:0] A_NUM  = ADDR_W'(16'h130);
  localparam logic [ADDR_W-1:0] A_CTL  = ADDR_W'(16'h138);
  localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(16'h140);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(16'h160);
  localparam logic [ADDR_W-1:0] A_ERR  = ADDR_W'(16'h170);

  typedef enum logic [3:0] {
    S_IDLE, S_W_CTL0, S_W_DSML, S_W_DSMH, S_W_SRC, S_W_DST, S_W_NUM, S_W_CFG,
    S_W_CTL1, S_W_CTL3, S_GAP, S_R_STAT, S_R_ERR, S_W_STOP, S_FIN
  } state_t;

  state_t           state;
  logic             issued;
  logic [GAP_W-1:0] gap_cnt;
  logic [63:0]      dsm_q;
  logic [63:0]      src_q;
  logic [63:0]      dst_q;
  logic [31:0]      num_q;
  logic [63:0]      mode_q;

  function automatic logic [ADDR_W-1:0] addr_of(input state_t s);
    case (s)
      S_W_DSML: addr_of = A_DSML;
      S_W_DSMH: addr_of = A_DSMH;
      S_W_SRC:  addr_of = A_SRC;
      S_W_DST:  addr_of = A_DST;
      S_W_NUM:  addr_of = A_NUM;
      S_W_CFG:  addr_of = A_CFG;
      S_R_STAT: addr_of = A_STAT;
      S_R_ERR:  addr_of = A_ERR;
      default:  addr_of = A_CTL;
    endcase
  endfunction

  function automatic logic [63:0] wdata_of(input state_t s);
    case (s)
      S_W_DSML: wdata_of = {32'h0, dsm_q[31:0]};
      S_W_DSMH: wdata_of = {32'h0, dsm_q[63:32]};
      S_W_SRC:  wdata_of = src_q;
      S_W_DST:  wdata_of = dst_q;
      S_W_NUM:  wdata_of = {32'h0, num_q};
      S_W_CFG:  wdata_of = mode_q;
      S_W_CTL1: wdata_of = 64'd1;
      S_W_CTL3: wdata_of = 64'd3;
      S_W_STOP: wdata_of = 64'd1;
      default:  wdata_of = 64'd0;
    endcase
  endfunction

  function automatic state_t next_of(input state_t s);
    case (s)
      S_W_CTL0: next_of = S_W_DSML;
      S_W_DSML: next_of = S_W_DSMH;
      S_W_DSMH: next_of = S_W_SRC;
      S_W_SRC:  next_of = S_W_DST;
      S_W_DST:  next_of = S_W_NUM;
      S_W_NUM:  next_of = S_W_CFG;
      S_W_CFG:  next_of = S_W_CTL1;
      S_W_CTL1: next_of = S_W_CTL3;
      S_W_CTL3: next_of = S_GAP;
      default:  next_of = S_W_STOP;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      issued        <= 1'b0;
      gap_cnt       <= '0;
      csr_req_valid <= 1'b0;
      csr_req_write <= 1'b0;
      csr_req_addr  <= '0;
      csr_req_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      aborted       <= 1'b0;
      err_status    <= '0;
      poll_count    <= '0;
      dsm_q         <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      num_q         <= '0;
      mode_q        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dsm_q      <= cfg_dsm_base;
            src_q      <= cfg_src_addr;
            dst_q      <= cfg_dst_addr;
            num_q      <= cfg_num_lines;
            mode_q     <= cfg_mode;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            aborted    <= 1'b0;
            poll_count <= '0;
            busy       <= 1'b1;
            issued     <= 1'b0;
            state      <= S_W_CTL0;
          end
        end

        S_GAP: begin
          if (abort) begin
            aborted <= 1'b1;
            pass    <= 1'b0;
            gap_cnt <= '0;
            state   <= S_W_STOP;
          end else if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= S_R_STAT;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        S_FIN: state <= S_IDLE;

        // All CSR transaction states: issue, wait for accept, then (reads) wait for the response.
        default: begin
          if (!issued) begin
            csr_req_valid <= 1'b1;
            csr_req_write <= (state != S_R_STAT) && (state != S_R_ERR);
            csr_req_addr  <= addr_of(state);
            csr_req_wdata <= wdata_of(state);
            issued        <= 1'b1;
          end else if (csr_req_valid) begin
            if (csr_req_ready) begin
              csr_req_valid <= 1'b0;
              if (csr_req_write) begin
                issued <= 1'b0;
                if (state == S_W_STOP) begin
                  state <= S_FIN;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end else if (abort) begin
                  aborted <= 1'b1;
                  pass    <= 1'b0;
                  state   <= S_W_STOP;
                end else begin
                  state <= next_of(state);
                end
              end else if (state == S_R_STAT && poll_count != 16'hFFFF) begin
                poll_count <= poll_count + 16'd1;
              end
            end
          end else if (csr_rsp_valid) begin
            issued <= 1'b0;
            if (state == S_R_ERR) begin
              err_status <= csr_rsp_rdata;
              state      <= S_W_STOP;
              if (abort) begin
                aborted <= 1'b1;
                pass    <= 1'b0;
              end else begin
                pass <= (csr_rsp_rdata == 64'd0);
              end
            end else if (abort) begin
              aborted <= 1'b1;
              pass    <= 1'b0;
              state   <= S_W_STOP;
            end else if (csr_rsp_rdata[31:0] >= num_q) begin
              state <= S_R_ERR;
            end else if ({16'h0, poll_count} >= MAX_POLLS_U) begin
              timeout <= 1'b1;
              state   <= S_W_STOP;
            end else begin
              state <= S_GAP;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_he_lpbk_csr_sequencer.sv
// Scoreboard bench for he_lpbk_csr_sequencer: expected CSR traffic and run results are queued by stimulus, checked by a monitor.
module tb_he_lpbk_csr_sequencer;

  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [63:0] d;
  } req_t;

  typedef struct packed {
    logic        p;
    logic        t;
    logic        ab;
    logic        ce;
    logic [63:0] err;
    logic [15:0] pc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [63:0] cfg_dsm_base;
  logic [63:0] cfg_src_addr;
  logic [63:0] cfg_dst_addr;
  logic [31:0] cfg_num_lines;
  logic [63:0] cfg_mode;
  logic        csr_req_valid;
  logic        csr_req_ready;
  logic        csr_req_write;
  logic [15:0] csr_req_addr;
  logic [63:0] csr_req_wdata;
  logic        csr_rsp_valid;
  logic [63:0] csr_rsp_rdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic        aborted;
  logic [63:0] err_status;
  logic [15:0] poll_count;

  always #5 clk = ~clk;

  he_lpbk_csr_sequencer #(.ADDR_W(16), .POLL_GAP(2), .MAX_POLLS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_dsm_base(cfg_dsm_base), .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
    .cfg_num_lines(cfg_num_lines), .cfg_mode(cfg_mode),
    .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready), .csr_req_write(csr_req_write),
    .csr_req_addr(csr_req_addr), .csr_req_wdata(csr_req_wdata),
    .csr_rsp_valid(csr_rsp_valid), .csr_rsp_rdata(csr_rsp_rdata),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .aborted(aborted),
    .err_status(err_status), .poll_count(poll_count)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int rd_acc_cnt = 0;
  int rsp_cnt = 0;
  int stall_left = 0;
  logic [15:0] stall_addr = 16'h0;

  req_t exp_q[$];
  res_t res_q[$];
  logic [63:0] stat_q[$];
  logic [63:0] err_q[$];

  // Ready generator: optional stall of a chosen address for stall_left cycles.
  initial begin
    csr_req_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (csr_req_valid && csr_req_addr == stall_addr && stall_left > 0) begin
        csr_req_ready = 1'b0;
        stall_left--;
      end else begin
        csr_req_ready = 1'b1;
      end
    end
  end

  // Read responder: answers each accepted read two edges later from the scripted queues.
  logic [15:0] rsp_addr;
  initial begin
    csr_rsp_valid = 1'b0;
    csr_rsp_rdata = 64'd0;
    forever begin
      @(negedge clk);
      if (rst_n && csr_req_valid && csr_req_ready && !csr_req_write) begin
        rsp_addr = csr_req_addr;
        @(posedge clk); #1;
        @(posedge clk); #1;
        csr_rsp_valid = 1'b1;
        if (rsp_addr == 16'h160)
          csr_rsp_rdata = (stat_q.size() > 0) ? stat_q.pop_front() : 64'd0;
        else
          csr_rsp_rdata = (err_q.size() > 0) ? err_q.pop_front() : 64'd0;
        rsp_cnt++;
        @(posedge clk); #1;
        csr_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: request ordering, hold-under-stall, and results at done.
  req_t e;
  req_t prev;
  res_t r;
  logic prev_stall = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (!csr_req_valid || csr_req_write !== prev.w || csr_req_addr !== prev.a || csr_req_wdata !== prev.d) begin
          failures++;
          $display("FAIL hold: got v=%b w=%b a=%h d=%h, want v=1 w=%b a=%h d=%h",
                   csr_req_valid, csr_req_write, csr_req_addr, csr_req_wdata, prev.w, prev.a, prev.d);
        end
      end
      prev_stall = rst_n && csr_req_valid && !csr_req_ready;
      prev = '{w: csr_req_write, a: csr_req_addr, d: csr_req_wdata};
      if (csr_req_valid && csr_req_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL req: unexpected w=%b a=%h d=%h, want none", csr_req_write, csr_req_addr, csr_req_wdata);
        end else begin
          e = exp_q.pop_front();
          if (csr_req_write !== e.w || csr_req_addr !== e.a || (e.w && csr_req_wdata !== e.d)) begin
            failures++;
            $display("FAIL req: got w=%b a=%h d=%h, want w=%b a=%h d=%h",
                     csr_req_write, csr_req_addr, csr_req_wdata, e.w, e.a, e.d);
          end
        end
        if (!csr_req_write) rd_acc_cnt++;
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (res_q.size() == 0) begin
          failures++;
          $display("FAIL result: unexpected done, want none");
        end else begin
          r = res_q.pop_front();
          if (pass !== r.p || timeout !== r.t || aborted !== r.ab || busy !== 1'b0 ||
              poll_count !== r.pc || (r.ce && err_status !== r.err)) begin
            failures++;
            $display("FAIL result: got pass=%b to=%b ab=%b busy=%b pc=%0d err=%h, want pass=%b to=%b ab=%b busy=0 pc=%0d err=%h",
                     pass, timeout, aborted, busy, poll_count, err_status, r.p, r.t, r.ab, r.pc, r.err);
          end
        end
      end
    end
  end

  function automatic res_t mk_res(input logic p, input logic t, input logic ab, input logic ce,
                                  input logic [63:0] err, input logic [15:0] pc);
    return '{p: p, t: t, ab: ab, ce: ce, err: err, pc: pc};
  endfunction

  task automatic push_w(input logic [15:0] a, input logic [63:0] d);
    exp_q.push_back('{w: 1'b1, a: a, d: d});
  endtask

  task automatic push_r(input logic [15:0] a);
    exp_q.push_back('{w: 1'b0, a: a, d: 64'd0});
  endtask

  task automatic set_cfg(input logic [63:0] dsm, input logic [63:0] src, input logic [63:0] dst,
                         input logic [31:0] num, input logic [63:0] mode);
    cfg_dsm_base = dsm; cfg_src_addr = src; cfg_dst_addr = dst; cfg_num_lines = num; cfg_mode = mode;
  endtask

  task automatic push_cfg_writes();
    push_w(16'h138, 64'd0);
    push_w(16'h110, {32'h0, cfg_dsm_base[31:0]});
    push_w(16'h114, {32'h0, cfg_dsm_base[63:32]});
    push_w(16'h120, cfg_src_addr);
    push_w(16'h128, cfg_dst_addr);
    push_w(16'h130, {32'h0, cfg_num_lines});
    push_w(16'h140, cfg_mode);
    push_w(16'h138, 64'd1);
    push_w(16'h138, 64'd3);
  endtask

  // Pulse start, then scramble cfg so any late sampling shows up as a wrong write.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    set_cfg(~cfg_dsm_base, ~cfg_src_addr, ~cfg_dst_addr, ~cfg_num_lines, ~cfg_mode);
  endtask

  task automatic wait_done(input int target, input string nm);
    int n;
    n = 0;
    while (done_cnt < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL %s: done_cnt=%0d after %0d cycles, want %0d", nm, done_cnt, n, target);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || done_cnt != target) begin
      failures++;
      $display("FAIL %s end: pending_reqs=%0d done_cnt=%0d, want 0 and %0d", nm, exp_q.size(), done_cnt, target);
    end
  endtask

  task automatic check_reset(input string nm);
    checks++;
    if ({csr_req_valid, busy, done, pass, timeout, aborted} !== 6'b0 || err_status !== 64'd0 || poll_count !== 16'd0) begin
      failures++;
      $display("FAIL %s: v=%b busy=%b done=%b pass=%b to=%b ab=%b err=%h pc=%0d, want all 0",
               nm, csr_req_valid, busy, done, pass, timeout, aborted, err_status, poll_count);
    end
  endtask

  initial begin
    int n;
    int base;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    set_cfg(64'd0, 64'd0, 64'd0, 32'd0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: pass on third poll
    set_cfg(64'h1122_3344_5566_7788, 64'hA000_0000_0000_1000, 64'hB000_0000_0000_2000, 32'd8, 64'h5);
    push_cfg_writes();
    repeat (3) push_r(16'h160);
    push_r(16'h170);
    push_w(16'h138, 64'd1);
    stat_q = '{64'd2, 64'd5, 64'd8};
    err_q = '{64'd0};
    res_q.push_back(mk_res(1'b1, 1'b0, 1'b0, 1'b1, 64'd0, 16'd3));
    pulse_start();
    wait_done(1, "pass_run");

    // 2: ERROR nonzero
    set_cfg(64'hDEAD_BEEF_0000_1111, 64'h10, 64'h20, 32'd4, 64'h7);
    push_cfg_writes();
    push_r(16'h160);
    push_r(16'h170);
    push_w(16'h138, 64'd1);
    stat_q = '{64'd4};
    err_q = '{64'h4};
    res_q.push_back(mk_res(1'b0, 1'b0, 1'b0, 1'b1, 64'h4, 16'd1));
    pulse_start();
    wait_done(2, "err_run");

    // 3: timeout after MAX_POLLS=4 polls, no ERROR read
    set_cfg(64'h1, 64'h2, 64'h3, 32'd100, 64'h0);
    push_cfg_writes();
    repeat (4) push_r(16'h160);
    push_w(16'h138, 64'd1);
    stat_q = '{64'd1, 64'd2, 64'd3, 64'd4};
    res_q.push_back(mk_res(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 16'd4));
    pulse_start();
    wait_done(3, "timeout_run");

    // 4: 5-cycle stall on W_SRC, num_lines=0 completes on the first poll
    set_cfg(64'hCAFE_0000_F00D_0000, 64'h5555_AAAA_5555_AAAA, 64'h0123_4567_89AB_CDEF, 32'd0, 64'h3);
    push_cfg_writes();
    push_r(16'h160);
    push_r(16'h170);
    push_w(16'h138, 64'd1);
    stat_q = '{64'd0};
    err_q = '{64'd0};
    stall_addr = 16'h120;
    stall_left = 5;
    res_q.push_back(mk_res(1'b1, 1'b0, 1'b0, 1'b1, 64'd0, 16'd1));
    pulse_start();
    wait_done(4, "stall_run");

    // 5: start while busy ignored; abort in GAP after poll 1
    set_cfg(64'h77, 64'h88, 64'h99, 32'd8, 64'h1);
    push_cfg_writes();
    push_r(16'h160);
    push_w(16'h138, 64'd1);
    stat_q = '{64'd1};
    res_q.push_back(mk_res(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 16'd1));
    base = rsp_cnt;
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    pulse_start();
    n = 0;
    while (rsp_cnt == base && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    @(posedge clk); #1;
    abort = 1'b1;
    wait_done(5, "abort_run");
    abort = 1'b0;

    // 6: reset while a STATUS0 read awaits its response
    set_cfg(64'h5, 64'h6, 64'h7, 32'd8, 64'h2);
    push_cfg_writes();
    push_r(16'h160);
    base = rd_acc_cnt;
    pulse_start();
    n = 0;
    while (rd_acc_cnt == base && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    exp_q.delete();
    res_q.delete();
    stat_q.delete();
    err_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset("post_reset");

    // 7: fresh run after reset starts from CTL=0 with poll_count from 0
    set_cfg(64'hABCD, 64'h1234, 64'h5678, 32'd1, 64'h9);
    push_cfg_writes();
    push_r(16'h160);
    push_r(16'h170);
    push_w(16'h138, 64'd1);
    stat_q = '{64'd1};
    err_q = '{64'd0};
    res_q.push_back(mk_res(1'b1, 1'b0, 1'b0, 1'b1, 64'd0, 16'd1));
    pulse_start();
    wait_done(6, "after_reset_run");

    // 8: start and abort together: first write completes, then straight to stop
    set_cfg(64'h1, 64'h1, 64'h1, 32'd1, 64'h1);
    push_w(16'h138, 64'd0);
    push_w(16'h138, 64'd1);
    res_q.push_back(mk_res(1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 16'd0));
    abort = 1'b1;
    pulse_start();
    wait_done(7, "start_abort_run");
    abort = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
